// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Holds the loader FSM state encoding and stream framing sizes.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } loader_state_t;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted stream bytes into a 32-bit little-endian word.
// Ports: clk, n_rst, clr, push, din[7:0] in; word[31:0], word_full out.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_full
);

  localparam logic [1:0] LAST = 2'(WORD_BYTES - 1);

  logic [1:0] cnt;

  // New bytes enter at the top and slide down, so after four
  // pushes the first byte sits in [7:0] (little-endian).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt  <= '0;
      word <= '0;
    end else if (clr) begin
      cnt  <= '0;
      word <= '0;
    end else if (push) begin
      cnt  <= cnt + 2'd1;
      word <= {din, word[31:8]};
    end
  end

  // Fires on the edge that accepts the last byte of a word.
  assign word_full = push && (cnt == LAST);

endmodule

// File: rtl/instr_loader.sv
// Boot loader: streams bytes into instruction memory, holds core in reset.
// Ports: start, rx_valid/rx_data in; rx_ready, imem_*, core_hold, done, error out.
module instr_loader
  import loader_pkg::*;
#(
  parameter int NUM_INSTR = 1024
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] MAX_N = 32'(NUM_INSTR);

  loader_state_t state;
  loader_state_t state_nx;

  logic [15:0] idx;
  logic [15:0] len;
  logic [7:0]  len_lo;
  logic [7:0]  csum;
  logic [15:0] n_word;
  logic [15:0] idx_inc;
  logic        accept;
  logic        go;
  logic        too_long;
  logic        push;
  logic        word_full;
  logic        csum_in;
  logic [31:0] word;

  assign accept   = rx_valid && rx_ready;
  assign go       = start &&
                    (state inside {S_IDLE, S_DONE, S_ERR});
  assign n_word   = {rx_data, len_lo};
  assign too_long = {16'b0, n_word} > MAX_N;
  assign idx_inc  = idx + 16'd1;
  assign push     = accept && (state == S_DATA);
  // Length and payload bytes feed the checksum; the checksum
  // byte itself does not.
  assign csum_in  = accept &&
                    (state inside {S_LEN_LO, S_LEN_HI, S_DATA});

  byte_packer u_packer (
    .clk       (clk),
    .n_rst     (n_rst),
    .clr       (go),
    .push      (push),
    .din       (rx_data),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE,
      S_DONE,
      S_ERR: begin
        if (start) state_nx = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) state_nx = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) begin
          if (too_long)          state_nx = S_ERR;
          else if (n_word == 0)  state_nx = S_CSUM;
          else                   state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (word_full) state_nx = S_WRITE;
      end
      S_WRITE: begin
        state_nx = (idx_inc == len) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (accept)
          state_nx = (rx_data == csum) ? S_DONE : S_ERR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx    <= '0;
      len    <= '0;
      len_lo <= '0;
      csum   <= '0;
    end else begin
      if (go) begin
        idx  <= '0;
        csum <= '0;
      end else begin
        if (state == S_WRITE) idx <= idx_inc;
        if (csum_in) csum <= csum ^ rx_data;
      end
      if (accept && state == S_LEN_LO) len_lo <= rx_data;
      if (accept && state == S_LEN_HI) len    <= n_word;
    end
  end

  assign rx_ready   = state inside {S_LEN_LO, S_LEN_HI,
                                    S_DATA, S_CSUM};
  assign imem_we    = (state == S_WRITE);
  assign imem_addr  = {14'b0, idx, 2'b00};
  assign imem_wdata = word;
  assign core_hold  = (state != S_DONE);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader.
// Table-driven stream sessions plus hand sequences and a write scoreboard.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;

  instr_loader #(.NUM_INSTR(1024)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    string      name;
    int         n;
    int         send_n;
    bit         send_csum;
    logic [7:0] flip;
    bit         bp;
    bit         exp_done;
  } vec_t;

  wr_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  logic [7:0]  xs;
  logic [31:0] pw[0:1023];
  vec_t        tbl[7];

  always @(negedge clk) begin
    if (n_rst && imem_we) begin
      wr_t e;
      wr_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wr_extra addr %h data %h unexpected",
                 imem_addr, imem_wdata);
      end else begin
        e = sb.pop_front();
        if (imem_addr !== e.a || imem_wdata !== e.d) begin
          errors++;
          $display("FAIL wr_data got %h/%h want %h/%h",
                   imem_addr, imem_wdata, e.a, e.d);
        end
      end
      checks++;
      if (rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_write got %b want 0", rx_ready);
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bp);
    int w;
    int g;
    if (bp) begin
      g = int'($urandom_range(0, 3));
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    w = 0;
    while (!rx_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_timeout byte %h not accepted", b);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    xs = xs ^ b;
  endtask

  task automatic send_word(input logic [31:0] wd,
                           input int k, input bit bp);
    wr_t e;
    e.a = 32'(k) << 2;
    e.d = wd;
    sb.push_back(e);
    for (int i = 0; i < 4; i++)
      send_byte(wd[8*i +: 8], bp);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    xs = 8'h00;
    chk("start_ready", 32'(rx_ready), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_error", 32'(error), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    logic [15:0] n16;
    base = wr_count;
    n16 = 16'(v.n);
    do_start();
    send_byte(n16[7:0], v.bp);
    send_byte(n16[15:8], v.bp);
    for (int k = 0; k < v.send_n; k++)
      send_word(pw[k], k, v.bp);
    if (v.send_csum)
      send_byte(xs ^ v.flip, v.bp);
    @(negedge clk);
    chk({v.name, "_done"}, 32'(done), 32'(v.exp_done));
    chk({v.name, "_error"}, 32'(error), 32'(!v.exp_done));
    chk({v.name, "_hold"}, 32'(core_hold), 32'(!v.exp_done));
    chk({v.name, "_ready"}, 32'(rx_ready), 32'd0);
    chk({v.name, "_nwr"}, 32'(wr_count - base), 32'(v.send_n));
    chk({v.name, "_sb"}, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_ready"}, 32'(rx_ready), 32'd0);
    chk({nm, "_we"}, 32'(imem_we), 32'd0);
    chk({nm, "_addr"}, imem_addr, 32'd0);
    chk({nm, "_wdata"}, imem_wdata, 32'd0);
    chk({nm, "_hold"}, 32'(core_hold), 32'd1);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    int base;
    wr_t e;

    pw[0] = 32'h00A00513;
    pw[1] = 32'h00B00593;
    for (int i = 2; i < 1024; i++) pw[i] = $urandom;

    tbl[0] = '{"basic",    2,    2,    1'b1, 8'h00, 1'b0, 1'b1};
    tbl[1] = '{"backpr",   2,    2,    1'b1, 8'h00, 1'b1, 1'b1};
    tbl[2] = '{"badcsum",  2,    2,    1'b1, 8'h01, 1'b0, 1'b0};
    tbl[3] = '{"n0",       0,    0,    1'b1, 8'h00, 1'b0, 1'b1};
    tbl[4] = '{"nover",    1025, 0,    1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{"n5bp",     5,    5,    1'b1, 8'h00, 1'b1, 1'b1};
    tbl[6] = '{"nmax",     1024, 1024, 1'b1, 8'h00, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outs("idle");

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Start pulsed mid-word is ignored; also checks write and
    // done timing edge by edge.
    base = wr_count;
    do_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h05, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ign_ready", 32'(rx_ready), 32'd1);
    chk("ign_hold", 32'(core_hold), 32'd1);
    e.a = 32'h0;
    e.d = 32'h00A00513;
    sb.push_back(e);
    send_byte(8'hA0, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("ign_we", 32'(imem_we), 32'd1);
    chk("ign_wready", 32'(rx_ready), 32'd0);
    chk("ign_wdata", imem_wdata, 32'h00A00513);
    @(posedge clk);
    #1;
    chk("ign_csready", 32'(rx_ready), 32'd1);
    chk("ign_we_off", 32'(imem_we), 32'd0);
    send_byte(8'h01 ^ 8'h13 ^ 8'h05 ^ 8'hA0, 1'b0);
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_hold_rel", 32'(core_hold), 32'd0);
    chk("ign_nwr", 32'(wr_count - base), 32'd1);

    // Reset after two bytes of word 1.
    base = wr_count;
    do_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(pw[0], 0, 1'b0);
    send_byte(pw[1][7:0], 1'b0);
    send_byte(pw[1][15:8], 1'b0);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk_reset_outs("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset_outs("postrst");
    chk("midrst_nwr", 32'(wr_count - base), 32'd1);
    chk("midrst_sb", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;

    // Recovery: a fresh basic load works after the reset.
    run_vec(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader: the writer side of the instruction memory that `fetch_instr` reads. It accepts a byte stream over a valid/ready handshake, packs the bytes into 32-bit little-endian words, and writes them sequentially into instruction memory from address 0. While loading, it holds the core in reset and releases it only after a successful checksum. It sits beside `top`, driving the instruction-memory write port and gating the core's `n_rst`.

## Interface
- `NUM_INSTR`, default 1024: instruction memory depth in words; the maximum legal word count.
- `clk`  in  1: system clock.
- `n_rst`  in  1: reset, asynchronous and active-low.
- `start`  in  1: one-cycle pulse that begins a load session; honoured only in IDLE, DONE or ERR.
- `rx_valid`  in  1: byte available on `rx_data`.
- `rx_data`  in  8: stream byte.
- `rx_ready`  out  1: loader accepts a byte this cycle.
- `imem_we`  out  1: one-cycle instruction-memory write strobe.
- `imem_addr`  out  32: byte address (word index << 2), the same format as PC.
- `imem_wdata`  out  32: assembled instruction word.
- `core_hold`  out  1: high means the core is held in reset.
- `done`  out  1: load succeeded; stays high until the next `start`.
- `error`  out  1: load failed; sticky until the next `start`.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N payload bytes (each word little-endian), then one checksum byte.
- Checksum = XOR of every byte from LEN_LO through the last payload byte.
- A byte is accepted on a rising edge where `rx_valid && rx_ready`. Unaccepted bytes must be held by the sender.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERR.
  - IDLE/DONE/ERR + `start` → LEN_LO. Clears `done`, `error`, the word index and the running XOR.
  - LEN_LO + accept → LEN_HI.
  - LEN_HI + accept:
    - N > NUM_INSTR → ERR.
    - N = 0 → CSUM.
    - Otherwise → DATA.
  - DATA + accept of the 4th byte of a word → WRITE.
  - WRITE (exactly one cycle): `imem_we`=1. Then the word index increments. If index = N → CSUM, else → DATA.
  - CSUM + accept: byte equals the running XOR → DONE, else → ERR.
- `start` in any other state is ignored.
- Outputs by state:
  - `rx_ready` = 1 in LEN_LO, LEN_HI, DATA and CSUM; 0 elsewhere.
  - `core_hold` = 0 only in DONE.
  - `done` = 1 only in DONE; `error` = 1 only in ERR.
- Width rules:
  - The word index is 16 bits and cannot wrap, because N ≤ NUM_INSTR ≤ 65535.
  - `imem_addr` = {14'b0, index, 2'b00}, computed as a 32-bit value.
- Reset mid-load returns the FSM to IDLE. The partial word is discarded and no write is issued; words already written stay in memory.
- Reset values: `rx_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_hold`=1, `done`=0, `error`=0.

## Timing
- All outputs are registered or decoded from the state register; there is no combinational path from `rx_valid` to `rx_ready`.
- `start` sampled at edge t → `rx_ready`=1 from cycle t+1.
- 4th byte of word k accepted at edge t:
  - During cycle t+1: `imem_we`=1, `imem_addr`=4k, `imem_wdata`={b3,b2,b1,b0}, `rx_ready`=0.
  - `rx_ready` returns to 1 in cycle t+2, unless the state is now CSUM, in which case it is still 1 for the checksum byte.
- Best-case throughput: one word per 5 cycles.
- Checksum byte accepted at edge t → `done` or `error` high in cycle t+1. `core_hold` falls in the same cycle as `done` rises.

## Structure
- Package `loader_pkg` holds:
  - the state enum `loader_state_t`;
  - `LEN_BYTES`=2 and `WORD_BYTES`=4.
- Sub-module `byte_packer` contains:
  - the 2-bit byte counter;
  - the 32-bit little-endian shift/assemble register;
  - the output `word_full`.
- The FSM, the word index and the running XOR stay in `instr_loader`.

## Test plan
- **Basic load.** Reset, `start`, stream 02 00 | 13 05 A0 00 | 93 05 B0 00 | checksum. Two writes are required:
  - addr 0x0, data 0x00A00513;
  - addr 0x4, data 0x00B00593.
  - Then `done`=1 and `core_hold`=0.
- **Backpressure from the sender.** Drop `rx_valid` for 3 random cycles between bytes. Writes and their data must be identical to the basic load, and exactly one `imem_we` is issued per word.
- **Bad checksum.** The basic-load stream with the checksum XORed with 0x01 → `error`=1, `done`=0, `core_hold` stays 1. A new `start` then clears `error`.
- **Length limits.**
  - N=0 (00 00, checksum 00) → `done` with no writes.
  - N=NUM_INSTR+1 (for 1024: 01 04) → ERR right after LEN_HI, with no writes.
- **Reset mid-load.** Assert `n_rst` after 2 bytes of word 1 → all outputs return to reset values, word 1 is never written, and the FSM waits in IDLE.
- **Ignored start.** Pulse `start` during DATA → no effect; the load completes normally.
